// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage sequencer.
package fetch_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP   = 32'd4;
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DROP,
        S_OUT
    } fetch_state_t;
endpackage

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, issues one imem read at a time,
// and hands the returned instruction to decode; redirects squash the old path.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc
);

    fetch_state_t    state, state_next;
    logic [XLEN-1:0] pc, pc_next;
    logic [XLEN-1:0] instr_next, opc_next;
    logic [XLEN-1:0] target;

    assign target         = {redirect_pc[XLEN-1:2], 2'b00};
    assign imem_req_valid = (state == S_REQ);
    assign imem_req_addr  = pc;
    assign out_valid      = (state == S_OUT) && !redirect_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            pc        <= {RESET_PC[XLEN-1:2], 2'b00};
            out_instr <= '0;
            out_pc    <= '0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            out_instr <= instr_next;
            out_pc    <= opc_next;
        end
    end

    // Redirect wins over every other event; a fetch already accepted by
    // memory must still drain its response through S_DROP.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        instr_next = out_instr;
        opc_next   = out_pc;
        case (state)
            S_IDLE: begin
                state_next = S_REQ;
                if (redirect_valid) pc_next = target;
            end
            S_REQ: begin
                if (redirect_valid) begin
                    pc_next    = target;
                    state_next = imem_req_ready ? S_DROP : S_REQ;
                end else if (imem_req_ready) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    pc_next    = target;
                    state_next = imem_rsp_valid ? S_REQ : S_DROP;
                end else if (imem_rsp_valid) begin
                    instr_next = imem_rsp_data;
                    opc_next   = pc;
                    state_next = S_OUT;
                end
            end
            S_DROP: begin
                if (redirect_valid) pc_next = target;
                if (imem_rsp_valid) state_next = S_REQ;
            end
            S_OUT: begin
                if (redirect_valid) begin
                    pc_next    = target;
                    state_next = S_REQ;
                end else if (out_ready) begin
                    pc_next    = pc + PC_STEP;
                    state_next = S_REQ;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // A response with no fetch outstanding indicates a broken memory model.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(imem_rsp_valid && !(state inside {S_WAIT, S_DROP})));
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: directed stimulus pushes expected
// (pc, instr) pairs; a monitor pops them on every decode handshake.
module tb_fetch_ctrl;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    logic        w_req_valid;
    logic [31:0] w_req_addr;
    logic        w_rsp_valid = 1'b0;
    logic        w_out_valid;
    logic [31:0] w_out_instr;
    logic [31:0] w_out_pc;
    logic [31:0] w_addrs[$];

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          delivered = 0;
    int          mem_lat = 1;
    logic        pending = 1'b0;
    logic [31:0] paddr = '0;
    int          cnt = 0;
    logic        w_acc;

    always #5 clk = ~clk;

    fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc)
    );

    fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(reset),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .imem_req_valid(w_req_valid), .imem_req_ready(1'b1),
        .imem_req_addr(w_req_addr),
        .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(32'hCAFE_0013),
        .out_valid(w_out_valid), .out_ready(1'b1),
        .out_instr(w_out_instr), .out_pc(w_out_pc)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[23:0], 8'h13};
    endfunction

    // Memory model: one outstanding read, response mem_lat cycles after acceptance.
    always @(posedge clk) begin
        if (reset) begin
            pending = 1'b0;
        end else begin
            if (pending) begin
                if (cnt == 0) pending = 1'b0;
                else cnt = cnt - 1;
            end
            if (imem_req_valid && imem_req_ready) begin
                pending = 1'b1;
                paddr   = imem_req_addr;
                cnt     = mem_lat - 1;
            end
        end
        #1;
        imem_rsp_valid = pending && (cnt == 0);
        imem_rsp_data  = mem_word(paddr);
    end

    always @(posedge clk) begin
        w_acc = !reset && w_req_valid;
        if (w_acc) w_addrs.push_back(w_req_addr);
        #1;
        w_rsp_valid = w_acc;
    end

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            exp_t e;
            delivered++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_delivery: got pc=%h instr=%h, required none", out_pc, out_instr);
            end else begin
                e = exp_q.pop_front();
                if (out_pc !== e.pc || out_instr !== e.instr) begin
                    errors++;
                    $display("[TB] FAIL delivery: got pc=%h instr=%h, required pc=%h instr=%h",
                             out_pc, out_instr, e.pc, e.instr);
                end
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic apply_stimulus(input logic rv, input logic [31:0] rpc,
                                  input logic rr, input logic ordy);
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_req_ready = rr;
        out_ready      = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] pc);
        exp_q.push_back('{pc: pc, instr: mem_word(pc)});
    endtask

    task automatic wait_delivered(input int target);
        for (int i = 0; i < 60 && delivered < target; i++) apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1);
        check_output("delivery_timeout", 32'(delivered >= target), 32'd1);
    endtask

    task automatic wait_out_valid();
        for (int i = 0; i < 60 && !out_valid; i++) apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
        check_output("out_valid_timeout", {31'b0, out_valid}, 32'd1);
    endtask

    task automatic wait_req_valid();
        for (int i = 0; i < 60 && !imem_req_valid; i++) apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
        check_output("req_valid_timeout", {31'b0, imem_req_valid}, 32'd1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        check_output("reset_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check_output("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check_output("reset_out_pc", out_pc, 32'h0);
        check_output("reset_out_instr", out_instr, 32'h0);

        // Back-to-back fetches with 1-cycle memory.
        push_exp(32'h0); push_exp(32'h4); push_exp(32'h8); push_exp(32'hC);
        wait_delivered(4);

        // Decode stalls: output must hold and no new request may issue.
        push_exp(32'h10);
        wait_out_valid();
        for (int i = 0; i < 5; i++) begin
            check_output("stall_out_valid", {31'b0, out_valid}, 32'd1);
            check_output("stall_out_pc", out_pc, 32'h10);
            check_output("stall_out_instr", out_instr, mem_word(32'h10));
            check_output("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
            apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
        end
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1);

        // Memory back-pressure: request held stable.
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);
            check_output("bp_req_valid", {31'b0, imem_req_valid}, 32'd1);
            check_output("bp_req_addr", imem_req_addr, 32'h14);
            check_output("bp_rsp_valid", {31'b0, imem_rsp_valid}, 32'd0);
        end
        push_exp(32'h14);
        wait_delivered(6);

        // Redirect while waiting on a 3-cycle response.
        mem_lat = 3;
        push_exp(32'h100);
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
        apply_stimulus(1'b1, 32'h100, 1'b1, 1'b0);
        check_output("wait_redir_req_valid", {31'b0, imem_req_valid}, 32'd0);
        wait_req_valid();
        check_output("wait_redir_addr", imem_req_addr, 32'h100);
        wait_delivered(7);

        // Redirect on the request handshake; low target bits are dropped.
        mem_lat = 2;
        push_exp(32'h200);
        apply_stimulus(1'b1, 32'h203, 1'b1, 1'b0);
        check_output("hs_redir_req_valid", {31'b0, imem_req_valid}, 32'd0);
        wait_req_valid();
        check_output("hs_redir_addr", imem_req_addr, 32'h200);
        wait_delivered(8);

        // Redirect while presenting to decode: no transfer.
        mem_lat = 1;
        push_exp(32'h300);
        wait_out_valid();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        out_ready      = 1'b1;
        #1;
        check_output("out_redir_out_valid", {31'b0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        wait_delivered(9);
        check_output("queue_empty", exp_q.size(), 32'd0);

        // PC wrap from 0xFFFF_FFFC.
        if (w_addrs.size() >= 2) begin
            check_output("wrap_first_addr", w_addrs[0], 32'hFFFF_FFFC);
            check_output("wrap_second_addr", w_addrs[1], 32'h0);
        end else begin
            check_output("wrap_fetch_count", w_addrs.size(), 32'd2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
